// File: rtl/dmem_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_bus_bridge_pkg
// Brief    : State encoding and error codes shared by the data-memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_bus_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_BUS  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_ALIGN   = 2'd1;
    localparam logic [1:0] c_ERR_BUS     = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bus_timeout_counter
// Brief    : Counts bus-wait cycles; o_expired marks the TIMEOUT-th cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                 c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    // Count is 0 in the first wait cycle, so the limit is hit in cycle TIMEOUT.
    assign o_expired = (r_count == c_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_bridge
// Brief    : CPU data-memory port to req/ack bus bridge with stall, alignment
//            check, bus timeout, sticky error and transaction counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_req;
    logic       w_misaligned;
    logic       w_issue;
    logic       w_rd_ok;
    logic       w_wr_ok;
    logic       w_fail;
    logic [1:0] w_fail_code;
    logic       w_expired;
    logic       w_bus_end;

    assign w_req        = cpu_memread | cpu_memwrite;
    assign w_misaligned = (cpu_addr[2:0] != 3'b000);
    assign cpu_stall    = ((r_state == c_ST_IDLE) && w_req) || (r_state == c_ST_BUS);
    assign w_bus_end    = (r_state == c_ST_BUS) && (w_state_next == c_ST_DONE);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (CLK),
        .rst       (resetl),
        .i_clear   (w_issue),
        .i_enable  (r_state == c_ST_BUS),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_rd_ok      = 1'b0;
        w_wr_ok      = 1'b0;
        w_fail       = 1'b0;
        w_fail_code  = c_ERR_NONE;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    if (w_misaligned) begin
                        w_state_next = c_ST_DONE;
                        w_fail       = 1'b1;
                        w_fail_code  = c_ERR_ALIGN;
                    end else begin
                        w_state_next = c_ST_BUS;
                        w_issue      = 1'b1;
                    end
                end
            end
            c_ST_BUS: begin
                // A late ack in the final wait cycle still wins over the timeout.
                if (bus_ack) begin
                    w_state_next = c_ST_DONE;
                    if (bus_err) begin
                        w_fail      = 1'b1;
                        w_fail_code = c_ERR_BUS;
                    end else if (bus_we) begin
                        w_wr_ok = 1'b1;
                    end else begin
                        w_rd_ok = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_next = c_ST_DONE;
                    w_fail       = 1'b1;
                    w_fail_code  = c_ERR_TIMEOUT;
                end
            end
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
            err       <= 1'b0;
            err_code  <= c_ERR_NONE;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (w_issue) begin
                bus_req   <= 1'b1;
                bus_we    <= cpu_memwrite;
                bus_addr  <= cpu_addr;
                bus_wdata <= cpu_wdata;
            end
            if (w_bus_end) begin
                bus_req <= 1'b0;
            end
            if (w_rd_ok) begin
                cpu_rdata <= bus_rdata;
                rd_count  <= rd_count + CNT_W'(1);
            end
            if (w_wr_ok) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            // Any failed access returns zero load data; only the first code sticks.
            if (w_fail) begin
                cpu_rdata <= '0;
                err       <= 1'b1;
                if (!err) begin
                    err_code <= w_fail_code;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Sits directly downstream of the single-cycle processor's data-memory port. Converts the CPU's one-cycle MemoryRead/MemoryWrite request into a registered req/ack bus transaction toward a variable-latency memory. Holds the core with a stall output until data returns or the request fails. Adds alignment checking, a bus timeout, sticky error reporting and read/write transaction counters.

Parameters:
ADDR_W, 64, address width (matches ALU output)
DATA_W, 64, data width (matches register file bus)
TIMEOUT, 255, max cycles in BUS state before abort (>=1)
CNT_W, 32, width of transaction counters

Ports:
CLK  in  1  clock; all state changes on rising edge
resetl  in  1  reset resetl, synchronous, active-high
cpu_addr  in  ADDR_W  byte address from ALU result
cpu_wdata  in  DATA_W  store data (register B output)
cpu_memread  in  1  load request
cpu_memwrite  in  1  store request
cpu_rdata  out  DATA_W  load data to MemtoReg mux
cpu_stall  out  1  hold PC/regfile while high
bus_req  out  1  registered bus request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  ADDR_W  latched address
bus_wdata  out  DATA_W  latched write data
bus_rdata  in  DATA_W  read data, valid with bus_ack
bus_ack  in  1  transfer complete
bus_err  in  1  slave error, valid with bus_ack
err  out  1  sticky error flag
err_code  out  2  first error: 0 none, 1 misaligned, 2 bus_err, 3 timeout
rd_count  out  CNT_W  completed loads
wr_count  out  CNT_W  completed stores

Behaviour:
- States: IDLE, BUS, DONE.
- Reset (sync, resetl=1 at rising edge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, err=0, err_code=0, rd_count=0, wr_count=0. Applies mid-transaction: bus_req low the next cycle; a late bus_ack in IDLE is ignored.
- cpu_stall is combinational: 1 when (IDLE and (memread or memwrite)) or BUS; 0 in DONE and in IDLE with no request.
- IDLE, request present:
  - If both memread and memwrite are asserted, treat as a write.
  - If cpu_addr[2:0]!=0: no bus cycle; go to DONE; cpu_rdata=0; record error code 1.
  - Otherwise latch addr, wdata and we; assert bus_req; clear the timeout counter; go to BUS.
- BUS:
  - bus_req, addr, we and wdata stay stable until bus_ack is sampled high.
  - On ack: bus_req=0; for reads, cpu_rdata<=bus_rdata; go to DONE.
  - If bus_err is high with ack: cpu_rdata<=0; record error code 2.
  - If the counter reaches TIMEOUT with no ack: bus_req=0; cpu_rdata<=0; record error code 3; go to DONE.
- DONE: one cycle; stall=0; cpu_rdata valid; always goes to IDLE. The request still asserted during DONE is not re-issued. A new request is only evaluated in IDLE.
- Latency: zero-wait slave (ack in first BUS cycle) gives 2 stall cycles. Ack after N BUS cycles gives N+1 stall cycles.
- err is set on any error. err_code captures the first error only; later errors do not overwrite it until reset.
- rd_count/wr_count increment on entry to DONE for successful transfers only; they wrap modulo 2^CNT_W.
- cpu_rdata holds its value outside DONE. Writes do not modify cpu_rdata.

Decomposition:
- Shared package: state encoding (IDLE/BUS/DONE), err_code constants (ERR_NONE, ERR_ALIGN, ERR_BUS, ERR_TIMEOUT).
- One natural sub-module: bus_timeout_counter (clear, enable, expired output, parameter TIMEOUT).

Test Plan:
- Read 0x40, slave acks in 3rd BUS cycle with 0xDEADBEEF -> cpu_stall high 4 cycles; cpu_rdata=0xDEADBEEF in DONE; rd_count=1; err=0.
- Write 0x80 data 0x1234, zero-wait ack -> bus_we=1, bus_addr=0x80, bus_wdata=0x1234 held one cycle; stall 2 cycles; wr_count=1.
- Read 0x43 -> no bus_req ever; stall 1 cycle; err=1, err_code=1; rd_count=0.
- Read 0x10, slave never acks, TIMEOUT=4 -> bus_req high 4 cycles then low; cpu_rdata=0; err_code=3.
- Write with bus_ack and bus_err together, then a later misaligned access -> err_code stays 2; wr_count unchanged.
- resetl=1 during BUS, then ack arrives in IDLE -> bus_req=0 next cycle; all outputs at reset values; ack ignored; counters 0.
